// File: rtl/tournament_selector.sv
// Tournament selector: draws pseudo-random cache address pairs, keeps the lowest-error
// individual across Rounds pair-draws and offers the winner over a valid/ready handshake.
module tournament_selector #(
    parameter int unsigned IndividualWidth = 32,
    parameter int unsigned AddressWidth    = 6,
    parameter int unsigned ErrorWidth      = 32,
    parameter int unsigned Rounds          = 1,
    parameter logic [31:0] Seed            = 32'h1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    output logic [AddressWidth-1:0]    addrIndividual1,
    output logic [AddressWidth-1:0]    addrIndividual2,
    input  logic [IndividualWidth-1:0] inIndividual1,
    input  logic [ErrorWidth-1:0]      inError1,
    input  logic [IndividualWidth-1:0] inIndividual2,
    input  logic [ErrorWidth-1:0]      inError2,
    output logic [IndividualWidth-1:0] outParent,
    output logic [ErrorWidth-1:0]      outError,
    output logic [AddressWidth-1:0]    outAddr,
    output logic                       outValid,
    input  logic                       outReady
);
    localparam int unsigned RoundWidth = $clog2(Rounds + 1);
    localparam logic [31:0] LfsrTaps   = 32'h8020_0003;
    localparam logic [31:0] SeedInit   = (Seed == 32'h0) ? 32'h1 : Seed;
    localparam logic [RoundWidth-1:0] RoundLast = RoundWidth'(Rounds);

    typedef enum logic [1:0] {IDLE, FETCH, COMPARE, OFFER} state_e;

    state_e                     state_q, state_d;
    logic [31:0]                lfsr_q, lfsr_d;
    logic [RoundWidth-1:0]      round_q, round_d;
    logic [AddressWidth-1:0]    addr1_q, addr1_d, addr2_q, addr2_d;
    logic [IndividualWidth-1:0] cand_ind1_q, cand_ind1_d, cand_ind2_q, cand_ind2_d;
    logic [ErrorWidth-1:0]      cand_err1_q, cand_err1_d, cand_err2_q, cand_err2_d;
    logic [IndividualWidth-1:0] champ_ind_q, champ_ind_d;
    logic [ErrorWidth-1:0]      champ_err_q, champ_err_d;
    logic [AddressWidth-1:0]    champ_addr_q, champ_addr_d;
    logic [IndividualWidth-1:0] out_parent_q, out_parent_d;
    logic [ErrorWidth-1:0]      out_error_q, out_error_d;
    logic [AddressWidth-1:0]    out_addr_q, out_addr_d;
    logic                       out_valid_q, out_valid_d;

    logic [AddressWidth-1:0]    pair_addr1, pair_addr2;
    logic [31:0]                lfsr_step;
    logic [IndividualWidth-1:0] win_ind, best_ind;
    logic [ErrorWidth-1:0]      win_err, best_err;
    logic [AddressWidth-1:0]    win_addr, best_addr;
    logic [RoundWidth-1:0]      round_inc;
    logic                       load_pair;

    // Next address pair and LFSR successor, both derived from the pre-step value
    always_comb begin
        pair_addr1 = lfsr_q[AddressWidth-1:0];
        pair_addr2 = lfsr_q[2*AddressWidth-1:AddressWidth];
        if (pair_addr2 == pair_addr1) begin
            pair_addr2 = pair_addr1 + AddressWidth'(1);
        end
        lfsr_step = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LfsrTaps : 32'h0);
    end

    // Pair winner (ties keep port 1) and champion update (first round always takes it)
    always_comb begin
        if (cand_err2_q < cand_err1_q) begin
            win_ind  = cand_ind2_q;
            win_err  = cand_err2_q;
            win_addr = addr2_q;
        end else begin
            win_ind  = cand_ind1_q;
            win_err  = cand_err1_q;
            win_addr = addr1_q;
        end
        if ((round_q == '0) || (win_err < champ_err_q)) begin
            best_ind  = win_ind;
            best_err  = win_err;
            best_addr = win_addr;
        end else begin
            best_ind  = champ_ind_q;
            best_err  = champ_err_q;
            best_addr = champ_addr_q;
        end
        round_inc = round_q + RoundWidth'(1);
    end

    // Next-state and register-input logic
    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        round_d      = round_q;
        addr1_d      = addr1_q;
        addr2_d      = addr2_q;
        cand_ind1_d  = cand_ind1_q;
        cand_err1_d  = cand_err1_q;
        cand_ind2_d  = cand_ind2_q;
        cand_err2_d  = cand_err2_q;
        champ_ind_d  = champ_ind_q;
        champ_err_d  = champ_err_q;
        champ_addr_d = champ_addr_q;
        out_parent_d = out_parent_q;
        out_error_d  = out_error_q;
        out_addr_d   = out_addr_q;
        out_valid_d  = out_valid_q;
        load_pair    = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    load_pair = 1'b1;
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                cand_ind1_d = inIndividual1;
                cand_err1_d = inError1;
                cand_ind2_d = inIndividual2;
                cand_err2_d = inError2;
                state_d     = COMPARE;
            end
            COMPARE: begin
                champ_ind_d  = best_ind;
                champ_err_d  = best_err;
                champ_addr_d = best_addr;
                if (round_inc == RoundLast) begin
                    round_d      = '0;
                    out_parent_d = best_ind;
                    out_error_d  = best_err;
                    out_addr_d   = best_addr;
                    out_valid_d  = 1'b1;
                    state_d      = OFFER;
                end else begin
                    round_d   = round_inc;
                    load_pair = 1'b1;
                    state_d   = FETCH;
                end
            end
            OFFER: begin
                if (outReady) begin
                    out_valid_d = 1'b0;
                    if (enable) begin
                        load_pair = 1'b1;
                        state_d   = FETCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_pair) begin
            addr1_d = pair_addr1;
            addr2_d = pair_addr2;
            lfsr_d  = lfsr_step;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            lfsr_q       <= SeedInit;
            round_q      <= '0;
            addr1_q      <= '0;
            addr2_q      <= '0;
            cand_ind1_q  <= '0;
            cand_err1_q  <= '0;
            cand_ind2_q  <= '0;
            cand_err2_q  <= '0;
            champ_ind_q  <= '0;
            champ_err_q  <= '0;
            champ_addr_q <= '0;
            out_parent_q <= '0;
            out_error_q  <= '0;
            out_addr_q   <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            round_q      <= round_d;
            addr1_q      <= addr1_d;
            addr2_q      <= addr2_d;
            cand_ind1_q  <= cand_ind1_d;
            cand_err1_q  <= cand_err1_d;
            cand_ind2_q  <= cand_ind2_d;
            cand_err2_q  <= cand_err2_d;
            champ_ind_q  <= champ_ind_d;
            champ_err_q  <= champ_err_d;
            champ_addr_q <= champ_addr_d;
            out_parent_q <= out_parent_d;
            out_error_q  <= out_error_d;
            out_addr_q   <= out_addr_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign addrIndividual1 = addr1_q;
    assign addrIndividual2 = addr2_q;
    assign outParent       = out_parent_q;
    assign outError        = out_error_q;
    assign outAddr         = out_addr_q;
    assign outValid        = out_valid_q;
endmodule

// File: doc/tournament_selector.md
# tournament_selector

Read-side client of the individuals cache. Draws pseudo-random pairs of cache addresses and drives them onto the cache's two combinational read ports. Captures the returned individuals and errors, keeps the one with the lower error, and hands the winning parent to the crossover stage over a valid/ready handshake. Sits between the individuals cache and the crossover/mutation pipeline of the GA core.

## Interface
- IndividualWidth, 32, bits per individual (matches cache)
- AddressWidth, 6, cache address width; 2*AddressWidth <= 32 required
- ErrorWidth, 32, bits per error value (unsigned, lower is better)
- Rounds, 1, pair-draws per tournament (>=1); tournament size = 2*Rounds
- Seed, 32'h1, LFSR reset value; a value of 0 is replaced by 1

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-low (asserted when 0)
- enable  in  1  start/continue tournaments
- addrIndividual1  out  AddressWidth  cache read address, port 1
- addrIndividual2  out  AddressWidth  cache read address, port 2
- inIndividual1  in  IndividualWidth  cache data, port 1 (combinational)
- inError1  in  ErrorWidth  cache error, port 1
- inIndividual2  in  IndividualWidth  cache data, port 2
- inError2  in  ErrorWidth  cache error, port 2
- outParent  out  IndividualWidth  winning individual
- outError  out  ErrorWidth  winner's error
- outAddr  out  AddressWidth  winner's cache address
- outValid  out  1  winner available
- outReady  in  1  consumer accepts winner

## Operation
- LFSR: 32-bit Galois, taps 32'h80200003. It shifts one step each time an address pair is loaded.
- Pair load: addr1 = lfsr[AW-1:0], addr2 = lfsr[2AW-1:AW], both taken from the pre-step value. If addr2 == addr1, addr2 = addr1 + 1 mod 2^AW.
- States:
  - IDLE to FETCH on an edge with enable=1; pair loaded on that edge.
  - FETCH to COMPARE on the next edge; inIndividual/inError of both ports captured into candidate registers.
  - COMPARE to OFFER or FETCH on the next edge:
    - Pick the candidate winner: inError2 < inError1 selects port 2; otherwise port 1, so a tie goes to port 1.
    - Round 0: the champion is the candidate winner.
    - Later rounds: the candidate replaces the champion only if its error is strictly less.
    - Round counter increments.
    - If the counter reaches Rounds: load champion into out*, set outValid, go to OFFER, clear counter.
    - Otherwise: load a new pair and go to FETCH.
  - OFFER: out* and outValid held stable.
    - On an edge with outReady=1, outValid clears.
    - If enable=1 on that edge, a new pair is loaded and the state goes to FETCH; otherwise it goes to IDLE.
- enable is sampled only in IDLE and on the OFFER handshake edge. Deasserting it mid-tournament does not abort the tournament.
- Address outputs hold their last value in COMPARE, OFFER and IDLE.
- Cache writes between FETCH and capture are not tracked; captured values are the ones present at the FETCH-exit edge.

## Timing
- Reset (rst=0 at an edge):
  - State IDLE, lfsr=Seed, round counter 0.
  - addrIndividual1/2 = 0, outParent/outError/outAddr = 0, outValid = 0.
  - Candidate and champion registers = 0.
- Reset overrides every other event, including a handshake on the same edge.
- Latency: enable seen at edge E0. outValid is high after edge E0+2*Rounds (E2 when Rounds=1).
- Back-to-back throughput: with outReady and enable held at 1, a new winner is produced every 2*Rounds+1 cycles. outValid is low for 2*Rounds cycles between winners.
- outValid never drops without a handshake or a reset.
- A handshake edge with enable=0 leaves outValid=0 from the next cycle on, state IDLE.

## Test plan
- Reset: hold rst=0 for 2 edges while enable=1 and the cache holds random data. All outputs are 0 and outValid stays 0; release, then first addresses appear one edge after enable is seen.
- Rounds=1, Seed=32'h0000_0A05 (addr1=5, addr2=40), cache entry i = {individual=i, error=100-i}:
  - after 3 edges outValid=1, outAddr=40, outParent=40, outError=60.
- Collision, Seed=32'h0000_0041: addr1=1 and the raw addr2=1, so the driven addresses are addrIndividual1=1, addrIndividual2=2.
  - Collision wrap: Seed=32'h0000_0FFF gives addr2=0.
- Tie: all cache errors = 5. The winner is always the port-1 address, and the champion is never replaced across Rounds=3.
- Back-pressure: outReady=0 for 10 cycles after outValid rises. out* and outValid stay constant; with outReady=1 and enable=1, the next edge enters FETCH with the next LFSR pair.
- Reset mid-tournament: rst=0 during COMPARE. outValid=0 and addresses=0; after release the first pair again equals the Seed-derived pair from the Rounds=1 scenario (5, 40).
